// File: rtl/alu_decode_stage.sv
// RV32I decode stage: one-entry valid/ready register producing ALUOp, operand-B select and immediate.
// Define ALU_DECODE_ILLEGAL_EN to report undecodable words on the illegal output (tied to 0 otherwise).
module alu_decode_stage #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALUOp,
  output logic            alu_src_imm,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL = 4'b0110, OP_SRA = 4'b0111, OP_SLT = 4'b1000,
                         OP_SLTU = 4'b1001;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_JALR = 7'b1100111, OPC_STORE = 7'b0100011, OPC_BR = 7'b1100011,
                         OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? OP_SUB : OP_ADD;
      3'b001:  alu_fn = OP_SLL;
      3'b010:  alu_fn = OP_SLT;
      3'b011:  alu_fn = OP_SLTU;
      3'b100:  alu_fn = OP_XOR;
      3'b101:  alu_fn = alt ? OP_SRA : OP_SRL;
      3'b110:  alu_fn = OP_OR;
      default: alu_fn = OP_AND;
    endcase
  endfunction

  logic [31:0]     instr_q;
  logic            loaded_q;
  logic            out_valid_q, out_valid_d;
  logic            accept;

  logic [3:0]      dec_op;
  logic            dec_src;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // The held word is re-decoded from instr_q, so nothing combinational reaches the outputs from instr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q     <= RESET_INSTR;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept && !flush) begin
        instr_q  <= instr;
        loaded_q <= 1'b1;
      end
    end
  end

  assign opc   = instr_q[6:0];
  assign f3    = instr_q[14:12];
  assign f7    = instr_q[31:25];
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    dec_op  = OP_ADD;
    dec_src = 1'b0;
    dec_imm = '0;
    dec_ill = 1'b0;
    case (opc)
      OPC_R: begin
        dec_op  = alu_fn(f3, instr_q[30]);
        dec_ill = !((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_I: begin
        dec_op  = alu_fn(f3, (f3 == 3'b101) && instr_q[30]);
        dec_src = 1'b1;
        dec_imm = imm_i;
        if (f3 == 3'b001) dec_ill = (f7 != F7_BASE);
        if (f3 == 3'b101) dec_ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_LOAD, OPC_JALR: begin
        dec_src = 1'b1;
        dec_imm = imm_i;
        dec_ill = (opc == OPC_JALR) && (f3 != 3'b000);
      end
      OPC_STORE: begin
        dec_src = 1'b1;
        dec_imm = imm_s;
      end
      OPC_BR: begin
        dec_imm = imm_b;
        case (f3[2:1])
          2'b00:   dec_op = OP_SUB;
          2'b10:   dec_op = OP_SLT;
          2'b11:   dec_op = OP_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_src = 1'b1;
        dec_imm = imm_u;
      end
      OPC_JAL: begin
        dec_src = 1'b1;
        dec_imm = imm_j;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op  = OP_ADD;
      dec_src = 1'b0;
      dec_imm = '0;
    end
  end

  assign out_valid   = out_valid_q;
  assign ALUOp       = loaded_q ? dec_op : OP_ADD;
  assign alu_src_imm = loaded_q && dec_src;
  assign imm         = loaded_q ? dec_imm : '0;

`ifdef ALU_DECODE_ILLEGAL_EN
  assign illegal = loaded_q && out_valid_q && dec_ill;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected decode pushed on accept, popped when execute consumes.
module tb_alu_decode_stage;

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] instr = 32'h0, imm;
  logic [3:0]  ALUOp;
  logic        alu_src_imm, illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  op;
    logic        src;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  logic [37:0] sb [$];

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ALUOp(ALUOp),
    .alu_src_imm(alu_src_imm), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic load_vectors();
    vecs[0]  = '{32'h40B50533, 4'b0001, 1'b0, 32'h0000_0000, 1'b0}; // sub
    vecs[1]  = '{32'h4025D593, 4'b0111, 1'b1, 32'h0000_0402, 1'b0}; // srai
    vecs[2]  = '{32'hFE0508E3, 4'b0001, 1'b0, 32'hFFFF_FFF0, 1'b0}; // beq -16
    vecs[3]  = '{32'h00B50533, 4'b0000, 1'b0, 32'h0000_0000, 1'b0}; // add
    vecs[4]  = '{32'h00A5F5B3, 4'b0010, 1'b0, 32'h0000_0000, 1'b0}; // and
    vecs[5]  = '{32'hFFF50513, 4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0}; // addi -1
    vecs[6]  = '{32'h0000007F, 4'b0000, 1'b0, 32'h0000_0000, 1'b1}; // bad opcode
    vecs[7]  = '{32'h12345537, 4'b0000, 1'b1, 32'h1234_5000, 1'b0}; // lui
    vecs[8]  = '{32'h00A12223, 4'b0000, 1'b1, 32'h0000_0004, 1'b0}; // sw 4
    vecs[9]  = '{32'h0005C463, 4'b1000, 1'b0, 32'h0000_0008, 1'b0}; // blt +8
    vecs[10] = '{32'h0085D513, 4'b0110, 1'b1, 32'h0000_0008, 1'b0}; // srli 8
    vecs[11] = '{32'h40C5C533, 4'b0000, 1'b0, 32'h0000_0000, 1'b1}; // alt f7 with xor
    vecs[12] = '{32'h0080006F, 4'b0000, 1'b1, 32'h0000_0008, 1'b0}; // jal +8
    vecs[13] = '{32'h00B52533, 4'b1000, 1'b0, 32'h0000_0000, 1'b0}; // slt
    vecs[14] = '{32'h0000B517, 4'b0000, 1'b1, 32'h0000_B000, 1'b0}; // auipc
    vecs[15] = '{32'h00051067, 4'b0000, 1'b0, 32'h0000_0000, 1'b1}; // jalr f3!=0
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, ALUOp, alu_src_imm, imm, illegal, in_ready} !== {1'b0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_in_reset got v=%b op=%h src=%b imm=%h ill=%b rdy=%b exp v=0 op=0 src=0 imm=0 ill=0 rdy=1",
               out_valid, ALUOp, alu_src_imm, imm, illegal, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, ALUOp, alu_src_imm, imm, illegal} !== {1'b0, 4'b0, 1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_after_release got v=%b op=%h src=%b imm=%h ill=%b exp all zero",
               out_valid, ALUOp, alu_src_imm, imm, illegal);
    end
  endtask

  task automatic test_back_to_back(input bit randomise);
    int idx = 0;
    logic [37:0] exp, got;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = (idx < NV) && (!randomise || $urandom_range(0, 3) != 0);
      instr     = (idx < NV) ? vecs[idx].ins : 32'h0;
      out_ready = !randomise || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        got = {ALUOp, alu_src_imm, imm, illegal};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL bb_unexpected_entry got=%h exp=no entry", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL bb_decode got op=%h src=%b imm=%h ill=%b exp op=%h src=%b imm=%h ill=%b",
                     got[37:34], got[33], got[32:1], got[0], exp[37:34], exp[33], exp[32:1], exp[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({vecs[idx].op, vecs[idx].src, vecs[idx].imm, vecs[idx].ill & ILL_EN});
        idx++;
      end
      if (idx == NV && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (idx != NV || sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bb_drain got issued=%0d pending=%0d v=%b exp issued=%0d pending=0 v=0",
               idx, sb.size(), out_valid, NV);
    end
    sb.delete();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; instr = 32'h40B50533; out_ready = 1'b1;
    @(posedge clk); #1;
    instr = 32'h4025D593; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, ALUOp, alu_src_imm, imm} !== {1'b0, 1'b1, 4'b0001, 1'b0, 32'h0}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got rdy=%b v=%b op=%h src=%b imm=%h exp rdy=0 v=1 op=1 src=0 imm=0",
                 i, in_ready, out_valid, ALUOp, alu_src_imm, imm);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, ALUOp} !== {1'b1, 1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL stall_release got rdy=%b v=%b op=%h exp rdy=1 v=1 op=1", in_ready, out_valid, ALUOp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, ALUOp, alu_src_imm, imm} !== {1'b1, 4'b0111, 1'b1, 32'h0000_0402}) begin
      failures++;
      $display("FAIL stall_next_word got v=%b op=%h src=%b imm=%h exp v=1 op=7 src=1 imm=00000402",
               out_valid, ALUOp, alu_src_imm, imm);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_consume got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; instr = 32'h40B50533; out_ready = 1'b1;
    @(posedge clk); #1;
    instr = 32'h4025D593; flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b11) begin
      failures++;
      $display("FAIL flush_pre got rdy=%b v=%b exp rdy=1 v=1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop got v=%b exp v=0", out_valid);
    end
    in_valid = 1'b1; instr = 32'h00B52533; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stalled got v=%b exp v=0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = 32'h0000007F; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, illegal, ALUOp, alu_src_imm, imm} !== {1'b1, ILL_EN, 4'b0000, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL illegal_opcode got v=%b ill=%b op=%h src=%b imm=%h exp v=1 ill=%b op=0 src=0 imm=0",
               out_valid, illegal, ALUOp, alu_src_imm, imm, ILL_EN);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, illegal} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_complete got v=%b ill=%b exp v=0 ill=0", out_valid, illegal);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; instr = 32'h40B50533; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, ALUOp} !== {1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL midreset_pre got v=%b op=%h exp v=1 op=1", out_valid, ALUOp);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, ALUOp, alu_src_imm, imm, in_ready} !== {1'b0, 4'b0, 1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_async got v=%b op=%h src=%b imm=%h rdy=%b exp v=0 op=0 src=0 imm=0 rdy=1",
               out_valid, ALUOp, alu_src_imm, imm, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_stall();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
